// File: rtl/mult_pkg.sv
// Shared definitions for the product accumulator: parameter defaults,
// accumulator width derivation and the FSM state type.
package mult_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int GUARD_DEF = 4;

  function automatic int acc_w(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: clamps to the most positive/negative ACC_W-bit
// value when the two's-complement sum wraps.
module sat_add #(
  parameter int ACC_W = 36
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw_s;

  // Overflow only when both operands share a sign the raw result lacks
  always_comb begin
    raw_s = a + b;
    ovf   = (a[ACC_W-1] == b[ACC_W-1]) && (raw_s[ACC_W-1] != a[ACC_W-1]);
    if (ovf) begin
      sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum = raw_s;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a run of len signed products with saturation and a sticky
// overflow flag, then holds the result until the consumer takes it.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  GUARD = GUARD_DEF,
  localparam int ACC_W = acc_w(WIDTH, GUARD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         len,
  input  logic               prod_valid,
  input  logic [2*WIDTH-1:0] prod,
  output logic               prod_ready,
  output logic               sum_valid,
  output logic [ACC_W-1:0]   sum,
  input  logic               sum_ready,
  output logic               overflow,
  output logic               busy
);

  state_e           state_r, state_next_s;
  logic [ACC_W-1:0] acc_r;
  logic [7:0]       count_r;
  logic             ovf_r;
  logic             prod_ready_r, sum_valid_r, busy_r;
  logic             ready_next_s, valid_next_s, busy_next_s;
  logic             xfer_s;
  logic [ACC_W-1:0] prod_ext_s, sat_sum_s;
  logic             sat_ovf_s;

  assign xfer_s     = prod_valid && prod_ready_r;
  assign prod_ext_s = {{GUARD{prod[2*WIDTH-1]}}, prod};

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc_r),
    .b   (prod_ext_s),
    .sum (sat_sum_s),
    .ovf (sat_ovf_s)
  );

  // State register plus the registered, state-decoded handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      prod_ready_r <= 1'b0;
      sum_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      prod_ready_r <= ready_next_s;
      sum_valid_r  <= valid_next_s;
      busy_r       <= busy_next_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = (len == 8'd0) ? ST_HOLD : ST_ACCUM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (xfer_s && (count_r == 8'd1)) begin
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (sum_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    ready_next_s = 1'b0;
    valid_next_s = 1'b0;
    busy_next_s  = 1'b1;
    case (state_next_s)
      ST_IDLE:  busy_next_s  = 1'b0;
      ST_ACCUM: ready_next_s = 1'b1;
      ST_HOLD:  valid_next_s = 1'b1;
      default: begin
        ready_next_s = 1'b0;
        valid_next_s = 1'b0;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // Accumulator datapath: cleared on an accepted start, updated per transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= {ACC_W{1'b0}};
      count_r <= 8'd0;
      ovf_r   <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      acc_r   <= {ACC_W{1'b0}};
      count_r <= len;
      ovf_r   <= 1'b0;
    end else if ((state_r == ST_ACCUM) && xfer_s) begin
      acc_r   <= sat_sum_s;
      count_r <= count_r - 8'd1;
      ovf_r   <= ovf_r | sat_ovf_s;
    end else begin
      acc_r   <= acc_r;
      count_r <= count_r;
      ovf_r   <= ovf_r;
    end
  end

  assign prod_ready = prod_ready_r;
  assign sum_valid  = sum_valid_r;
  assign busy       = busy_r;
  assign sum        = acc_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomized bench for product_accumulator against an
// arithmetic reference model of saturating accumulation.
module tb_product_accumulator;

  localparam int WIDTH = 16;
  localparam int GUARD = 4;
  localparam int ACC_W = 2 * WIDTH + GUARD;
  localparam longint AMAX = 64'sd34359738367;
  localparam longint AMIN = -64'sd34359738368;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         len = 8'd0;
  logic               prod_valid = 1'b0;
  logic [2*WIDTH-1:0] prod = 32'd0;
  logic               prod_ready;
  logic               sum_valid;
  logic [ACC_W-1:0]   sum;
  logic               sum_ready = 1'b0;
  logic               overflow;
  logic               busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] pq[$];
  bit          vq[$];
  logic [63:0] exp_sum;
  bit          exp_ovf;

  product_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .sum_valid  (sum_valid),
    .sum        (sum),
    .sum_ready  (sum_ready),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] to_acc(input longint v);
    logic [63:0] u;
    u = v;
    return {28'd0, u[35:0]};
  endfunction

  // mode 0: prod_valid always high, 1: pattern from vq, 2: random
  task automatic run(input string tag, input int n_prod, input int mode);
    longint m = 0;
    bit     mo = 1'b0;
    int     n = 0;
    int     cyc = 0;
    int     pi = 0;
    longint p;
    start = 1'b1;
    len = n_prod[7:0];
    step();
    start = 1'b0;
    len = 8'($urandom);
    check({tag, "_busy_start"}, {63'd0, busy}, 64'd1);
    while (n < n_prod && cyc < 2000) begin
      if (mode == 0) prod_valid = 1'b1;
      else if (mode == 1) prod_valid = (pi < vq.size()) ? vq[pi] : 1'b1;
      else prod_valid = 1'($urandom_range(0, 1));
      pi++;
      prod = (n < pq.size()) ? pq[n] : 32'($urandom);
      if (prod_valid && prod_ready) begin
        p = longint'($signed(prod));
        m = m + p;
        if (m > AMAX) begin m = AMAX; mo = 1'b1; end
        if (m < AMIN) begin m = AMIN; mo = 1'b1; end
        n++;
      end
      step();
      cyc++;
      if (n < n_prod) begin
        check({tag, "_ready_mid"}, {63'd0, prod_ready}, 64'd1);
        check({tag, "_valid_mid"}, {63'd0, sum_valid}, 64'd0);
      end
    end
    prod_valid = 1'b0;
    check({tag, "_transfers"}, 64'(n), 64'(n_prod));
    exp_sum = to_acc(m);
    exp_ovf = mo;
    check({tag, "_sum_valid"}, {63'd0, sum_valid}, 64'd1);
    check({tag, "_sum"}, {28'd0, sum}, exp_sum);
    check({tag, "_overflow"}, {63'd0, overflow}, {63'd0, exp_ovf});
    check({tag, "_ready_hold"}, {63'd0, prod_ready}, 64'd0);
  endtask

  task automatic finish_hold(input string tag, input int k, input bit pulse);
    sum_ready = 1'b0;
    for (int i = 0; i < k; i++) begin
      start = pulse;
      len = 8'd5;
      step();
      check({tag, "_hold_sum"}, {28'd0, sum}, exp_sum);
      check({tag, "_hold_valid"}, {63'd0, sum_valid}, 64'd1);
      check({tag, "_hold_ovf"}, {63'd0, overflow}, {63'd0, exp_ovf});
    end
    start = pulse;
    sum_ready = 1'b1;
    step();
    start = 1'b0;
    sum_ready = 1'b0;
    check({tag, "_idle_valid"}, {63'd0, sum_valid}, 64'd0);
    check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_idle_ready"}, {63'd0, prod_ready}, 64'd0);
    step();
    check({tag, "_stay_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #12;
    check("rst_ready", {63'd0, prod_ready}, 64'd0);
    check("rst_valid", {63'd0, sum_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_sum", {28'd0, sum}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_no_start", {63'd0, busy}, 64'd0);

    // basic three-product run
    pq = '{32'd5, 32'hFFFF_FFFE, 32'd7};
    run("basic", 3, 0);
    check("basic_ten", {28'd0, sum}, 64'd10);
    finish_hold("basic", 1, 1'b0);

    // gaps in prod_valid
    pq = '{32'd100, 32'hFFFF_FED4};
    vq = '{1'b1, 1'b0, 1'b0, 1'b1};
    run("gaps", 2, 1);
    check("gaps_m200", {28'd0, sum}, 64'h0000_000F_FFFF_FF38);
    finish_hold("gaps", 0, 1'b0);

    // positive saturation, then overflow cleared by next start
    pq.delete();
    for (int i = 0; i < 32; i++) pq.push_back(32'h4000_0000);
    run("psat", 32, 0);
    check("psat_max", {28'd0, sum}, 64'h0000_0007_FFFF_FFFF);
    finish_hold("psat", 2, 1'b0);
    pq = '{32'd1};
    run("clr", 1, 0);
    check("clr_ovf0", {63'd0, overflow}, 64'd0);
    finish_hold("clr", 0, 1'b0);

    // negative saturation held after clamp
    pq.delete();
    for (int i = 0; i < 33; i++) pq.push_back(32'hC000_0000);
    run("nsat", 33, 0);
    check("nsat_min", {28'd0, sum}, 64'h0000_0008_0000_0000);
    finish_hold("nsat", 1, 1'b0);

    // zero-length run
    pq.delete();
    run("len0", 0, 0);
    finish_hold("len0", 0, 1'b0);

    // long hold with start pulsed, including at the exit handshake
    pq = '{32'd42, 32'hFFFF_FFF0};
    run("hold", 2, 0);
    finish_hold("hold", 5, 1'b1);

    // random runs
    for (int r = 0; r < 6; r++) begin
      int nl;
      nl = $urandom_range(1, 20);
      pq.delete();
      for (int i = 0; i < nl; i++) pq.push_back(($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($signed(16'($urandom))));
      run("rand", nl, 2);
      finish_hold("rand", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // reset mid-run
    pq = '{32'd11, 32'd22, 32'd33, 32'd44};
    start = 1'b1;
    len = 8'd4;
    step();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = pq[0];
    step();
    prod = pq[1];
    step();
    prod_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_sum", {28'd0, sum}, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_ready", {63'd0, prod_ready}, 64'd0);
    check("mrst_valid", {63'd0, sum_valid}, 64'd0);
    check("mrst_ovf", {63'd0, overflow}, 64'd0);
    step();
    #2;
    rst_n = 1'b1;
    step();
    check("mrst_wait", {63'd0, busy}, 64'd0);
    pq = '{32'd9};
    run("after_rst", 1, 0);
    check("after_rst_9", {28'd0, sum}, 64'd9);
    finish_hold("after_rst", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
